// File: rtl/calc_entry_if.sv
// Keypad, ALU and display bundle for the calculator entry FSM.
// Latency: none; this bundle is wiring only.
// Backpressure: none; keys are single-cycle strobes, results are single-cycle pulses.
interface calc_entry_if;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] alu_res;
    logic [15:0] num1;
    logic [15:0] num2;
    logic [3:0]  op;
    logic [15:0] disp;
    logic        res_valid;
    logic        busy;
    logic        err;

    // Keypad/ALU/display side of the bundle.
    modport master (
        output key_code, key_valid, alu_res,
        input  num1, num2, op, disp, res_valid, busy, err
    );

    // Calculator FSM side of the bundle.
    modport slave (
        input  key_code, key_valid, alu_res,
        output num1, num2, op, disp, res_valid, busy, err
    );
endinterface

// File: rtl/calc_entry_fsm.sv
// Calculator key-entry FSM: builds two 4-digit BCD operands, drives the ALU, shows the result.
// Latency: EQ strobe to res_valid is ALU_LAT+2 cycles; error results pulse res_valid 1 cycle after EQ.
// Backpressure: none; keys arriving while busy are dropped except CLR. Macro CALC_CHAIN_RESULT_EN enables result chaining.
module calc_entry_fsm #(
    parameter int ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    calc_entry_if.slave  io_calc
);
    typedef enum logic [1:0] {S_NUM1, S_NUM2, S_EXEC, S_RESULT} state_t;

    localparam int              CW        = $clog2(ALU_LAT + 2);
    localparam logic [CW-1:0]   CNT_LOAD  = CW'(ALU_LAT + 1);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [3:0]      K_CLR     = 4'hA;
    localparam logic [3:0]      K_EQ      = 4'hB;
    localparam logic [3:0]      K_SUB     = 4'hD;
    localparam logic [3:0]      K_DIV     = 4'hF;

    state_t        r_state;
    logic [15:0]   r_num1, r_num2, r_disp;
    logic [3:0]    r_op;
    logic [2:0]    r_cnt1, r_cnt2;
    logic [CW-1:0] r_wait;
    logic          r_res_valid, r_busy, r_err;

    state_t        w_state_nxt;
    logic [15:0]   w_num1_nxt, w_num2_nxt, w_disp_nxt;
    logic [3:0]    w_op_nxt;
    logic [2:0]    w_cnt1_nxt, w_cnt2_nxt;
    logic [CW-1:0] w_wait_nxt;
    logic          w_res_valid_nxt, w_err_nxt;

    logic w_digit, w_oper, w_eq, w_clr, w_eq_err;

    assign w_digit = io_calc.key_valid && (io_calc.key_code <= 4'd9);
    assign w_oper  = io_calc.key_valid && (io_calc.key_code >= 4'hC);
    assign w_eq    = io_calc.key_valid && (io_calc.key_code == K_EQ);
    assign w_clr   = io_calc.key_valid && (io_calc.key_code == K_CLR);
    // Valid BCD orders the same as plain binary, so a 16-bit compare is the digit-wise compare.
    assign w_eq_err = ((r_op == K_DIV) && (r_num2 == 16'h0000)) ||
                      ((r_op == K_SUB) && (r_num1 < r_num2));

    // State and datapath registers; reset wins over any key in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_NUM1;
            r_num1      <= '0;
            r_num2      <= '0;
            r_disp      <= '0;
            r_op        <= '0;
            r_cnt1      <= '0;
            r_cnt2      <= '0;
            r_wait      <= '0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_num1      <= w_num1_nxt;
            r_num2      <= w_num2_nxt;
            r_disp      <= w_disp_nxt;
            r_op        <= w_op_nxt;
            r_cnt1      <= w_cnt1_nxt;
            r_cnt2      <= w_cnt2_nxt;
            r_wait      <= w_wait_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_busy      <= (w_state_nxt == S_EXEC);
            r_err       <= w_err_nxt;
        end
    end

    // Next-state decode; CLR overrides every state including an in-flight ALU wait.
    always_comb begin
        w_state_nxt = r_state;
        if (w_clr) begin
            w_state_nxt = S_NUM1;
        end else begin
            case (r_state)
                S_NUM1:   if (w_oper) w_state_nxt = S_NUM2;
                S_NUM2:   if (w_eq) w_state_nxt = w_eq_err ? S_RESULT : S_EXEC;
                S_EXEC:   if (r_wait == '0) w_state_nxt = S_RESULT;
                S_RESULT: begin
                    if (w_digit) begin
                        w_state_nxt = S_NUM1;
                    end
`ifdef CALC_CHAIN_RESULT_EN
                    else if (w_oper && !r_err) begin
                        w_state_nxt = S_NUM2;
                    end
`endif
                end
                default:  w_state_nxt = S_NUM1;
            endcase
        end
    end

    // Datapath updates for the operands, operator, wait counter and result flags.
    always_comb begin
        w_num1_nxt      = r_num1;
        w_num2_nxt      = r_num2;
        w_disp_nxt      = r_disp;
        w_op_nxt        = r_op;
        w_cnt1_nxt      = r_cnt1;
        w_cnt2_nxt      = r_cnt2;
        w_wait_nxt      = r_wait;
        w_res_valid_nxt = 1'b0;
        w_err_nxt       = r_err;
        if (w_clr) begin
            w_num1_nxt = '0;
            w_num2_nxt = '0;
            w_disp_nxt = '0;
            w_op_nxt   = '0;
            w_cnt1_nxt = '0;
            w_cnt2_nxt = '0;
            w_wait_nxt = '0;
            w_err_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_NUM1: begin
                    if (w_digit && (r_cnt1 < 3'd4)) begin
                        w_num1_nxt = {r_num1[11:0], io_calc.key_code};
                        w_cnt1_nxt = r_cnt1 + 3'd1;
                    end else if (w_oper) begin
                        w_op_nxt   = io_calc.key_code;
                        w_num2_nxt = '0;
                        w_cnt2_nxt = '0;
                    end
                end
                S_NUM2: begin
                    if (w_digit && (r_cnt2 < 3'd4)) begin
                        w_num2_nxt = {r_num2[11:0], io_calc.key_code};
                        w_cnt2_nxt = r_cnt2 + 3'd1;
                    end else if (w_oper && (r_cnt2 == 3'd0)) begin
                        w_op_nxt = io_calc.key_code;
                    end else if (w_eq) begin
                        if (w_eq_err) begin
                            w_err_nxt       = 1'b1;
                            w_disp_nxt      = 16'hEEEE;
                            w_res_valid_nxt = 1'b1;
                        end else begin
                            w_wait_nxt = CNT_LOAD;
                        end
                    end
                end
                S_EXEC: begin
                    if (r_wait == '0) begin
                        w_disp_nxt      = io_calc.alu_res;
                        w_err_nxt       = 1'b0;
                        w_res_valid_nxt = 1'b1;
                    end else begin
                        w_wait_nxt = r_wait - CNT_ONE;
                    end
                end
                S_RESULT: begin
                    if (w_digit) begin
                        w_num1_nxt = {12'h000, io_calc.key_code};
                        w_cnt1_nxt = 3'd1;
                        w_num2_nxt = '0;
                        w_cnt2_nxt = '0;
                        w_op_nxt   = '0;
                        w_err_nxt  = 1'b0;
                    end
`ifdef CALC_CHAIN_RESULT_EN
                    else if (w_oper && !r_err) begin
                        w_num1_nxt = r_disp;
                        w_cnt1_nxt = 3'd4;
                        w_op_nxt   = io_calc.key_code;
                        w_num2_nxt = '0;
                        w_cnt2_nxt = '0;
                    end
`endif
                end
                default: ;
            endcase
        end
        // The display tracks whichever operand is being typed.
        if (w_state_nxt == S_NUM1) begin
            w_disp_nxt = w_num1_nxt;
        end else if (w_state_nxt == S_NUM2) begin
            w_disp_nxt = w_num2_nxt;
        end
    end

    assign io_calc.num1      = r_num1;
    assign io_calc.num2      = r_num2;
    assign io_calc.op        = r_op;
    assign io_calc.disp      = r_disp;
    assign io_calc.res_valid = r_res_valid;
    assign io_calc.busy      = r_busy;
    assign io_calc.err       = r_err;
endmodule

// File: tb/tb_calc_entry_fsm.sv
// Bench for calc_entry_fsm: directed key sequences then random keys against a digit-queue model.
// Latency: one step per clock; outputs sampled 1 ns after each rising edge.
// Backpressure: none; the bench's ALU answers after ALU_LAT cycles.
module tb_calc_entry_fsm;
    localparam int LAT = 2;
    localparam int P_ENTRY1 = 0, P_ENTRY2 = 1, P_WAIT = 2, P_SHOWN = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    calc_entry_if bus();
    calc_entry_fsm #(.ALU_LAT(LAT)) dut (.clk(clk), .rst_n(rst_n), .io_calc(bus));

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    function automatic int bcd2i(input logic [15:0] v);
        return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] i2bcd(input int x);
        logic [15:0] r;
        r[15:12] = 4'((x / 1000) % 10);
        r[11:8]  = 4'((x / 100) % 10);
        r[7:4]   = 4'((x / 10) % 10);
        r[3:0]   = 4'(x % 10);
        return r;
    endfunction

    function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b, input logic [3:0] o);
        int x, y, r;
        x = bcd2i(a);
        y = bcd2i(b);
        case (o)
            4'hC:    r = (x + y) % 10000;
            4'hD:    r = (x >= y) ? x - y : 0;
            4'hE:    r = (x * y) % 10000;
            4'hF:    r = (y != 0) ? x / y : 0;
            default: r = 0;
        endcase
        return i2bcd(r);
    endfunction

    // Bench ALU: ALU_LAT register stages fed from the DUT operands.
    logic [15:0] alu_pipe [LAT];
    initial for (int i = 0; i < LAT; i++) alu_pipe[i] = 16'h0000;
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) alu_pipe[i] <= alu_pipe[i-1];
        alu_pipe[0] <= alu_fn(bus.num1, bus.num2, bus.op);
    end
    assign bus.alu_res = alu_pipe[LAT-1];

    // Reference model: operands kept as lists of typed digits.
    int          ph;
    int          q1[$];
    int          q2[$];
    int          m_op;
    logic [15:0] m_disp;
    logic [15:0] m_res;
    bit          m_rv, m_err;
    int          deadline;

    function automatic logic [15:0] digits_to_bcd(input int q[$]);
        logic [15:0] v = 16'h0000;
        foreach (q[i]) v = {v[11:0], 4'(q[i])};
        return v;
    endfunction

    task automatic clear_model();
        ph = P_ENTRY1;
        q1.delete();
        q2.delete();
        m_op = 0;
        m_disp = 16'h0000;
        m_err = 1'b0;
    endtask

    task automatic model_edge(input bit kv, input logic [3:0] kc, input bit rn);
        int a, b;
        m_rv = 1'b0;
        if (!rn || (kv && kc == 4'hA)) begin
            clear_model();
        end else if (ph == P_WAIT) begin
            if (cyc == deadline) begin
                m_disp = m_res;
                m_err  = 1'b0;
                m_rv   = 1'b1;
                ph     = P_SHOWN;
            end
        end else if (kv) begin
            case (ph)
                P_ENTRY1: begin
                    if (kc <= 4'd9) begin
                        if (q1.size() < 4) q1.push_back(int'(kc));
                    end else if (kc >= 4'hC) begin
                        m_op = int'(kc);
                        q2.delete();
                        ph = P_ENTRY2;
                    end
                end
                P_ENTRY2: begin
                    if (kc <= 4'd9) begin
                        if (q2.size() < 4) q2.push_back(int'(kc));
                    end else if (kc >= 4'hC) begin
                        if (q2.size() == 0) m_op = int'(kc);
                    end else if (kc == 4'hB) begin
                        a = bcd2i(digits_to_bcd(q1));
                        b = bcd2i(digits_to_bcd(q2));
                        if ((m_op == 15 && b == 0) || (m_op == 13 && a < b)) begin
                            m_err  = 1'b1;
                            m_disp = 16'hEEEE;
                            m_rv   = 1'b1;
                            ph     = P_SHOWN;
                        end else begin
                            m_res    = alu_fn(digits_to_bcd(q1), digits_to_bcd(q2), 4'(m_op));
                            deadline = cyc + LAT + 2;
                            ph       = P_WAIT;
                        end
                    end
                end
                P_SHOWN: begin
                    if (kc <= 4'd9) begin
                        q1.delete();
                        q1.push_back(int'(kc));
                        q2.delete();
                        m_op  = 0;
                        m_err = 1'b0;
                        ph    = P_ENTRY1;
                    end
`ifdef CALC_CHAIN_RESULT_EN
                    else if (kc >= 4'hC && !m_err) begin
                        q1.delete();
                        for (int i = 3; i >= 0; i--) q1.push_back(int'(m_disp[i*4 +: 4]));
                        q2.delete();
                        m_op = int'(kc);
                        ph   = P_ENTRY2;
                    end
`endif
                end
                default: ;
            endcase
        end
        if (ph == P_ENTRY1) m_disp = digits_to_bcd(q1);
        if (ph == P_ENTRY2) m_disp = digits_to_bcd(q2);
    endtask

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input bit kv, input logic [3:0] kc, input bit rn);
        @(negedge clk);
        bus.key_valid = kv;
        bus.key_code  = kc;
        rst_n         = rn;
        @(posedge clk);
        cyc++;
        model_edge(kv, kc, rn);
        #1;
        check_val("num1", bus.num1, digits_to_bcd(q1));
        check_val("num2", bus.num2, digits_to_bcd(q2));
        check_val("op",   {12'h000, bus.op}, 16'(m_op));
        check_val("disp", bus.disp, m_disp);
        check_val("res_valid", {15'h0, bus.res_valid}, {15'h0, m_rv});
        check_val("busy", {15'h0, bus.busy}, {15'h0, (ph == P_WAIT)});
        check_val("err",  {15'h0, bus.err}, {15'h0, m_err});
    endtask

    task automatic press(input logic [3:0] k);
        step(1'b1, k, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'($urandom_range(0, 15)), 1'b1);
    endtask

    initial begin
        int n;
        int r;
        bit kv;
        logic [3:0] kc;
        rst_n = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        clear_model();
        m_rv = 1'b0;
        deadline = 0;
        m_res = 16'h0000;

        // Reset state, with a simultaneous key that must be ignored.
        step(1'b1, 4'h7, 1'b0);
        step(1'b0, 4'h0, 1'b0);
        idle(1);

        // 12 + 34 with the latency measured explicitly.
        press(4'h1); press(4'h2); press(4'hC); press(4'h3); press(4'h4);
        check_val("n1_0012", bus.num1, 16'h0012);
        check_val("n2_0034", bus.num2, 16'h0034);
        press(4'hB);
        n = 0;
        do begin idle(1); n++; end while (!bus.res_valid && n < 20);
        check_val("eq_lat", 16'(n), 16'(LAT + 2));
        check_val("disp_0046", bus.disp, 16'h0046);

        // Chain from the shown result: + 4 =.
        press(4'hC); press(4'h4); press(4'hB);
        idle(LAT + 3);
`ifdef CALC_CHAIN_RESULT_EN
        check_val("chain_n1", bus.num1, 16'h0046);
        check_val("chain_n2", bus.num2, 16'h0004);
`else
        check_val("nochain_n1", bus.num1, 16'h0004);
`endif

        // Fifth digit ignored.
        press(4'hA); press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
        check_val("n1_1234", bus.num1, 16'h1234);

        // Divide by zero, then a fresh digit.
        press(4'hA); press(4'h9); press(4'hF); press(4'h0); press(4'hB);
        check_val("div0_disp", bus.disp, 16'hEEEE);
        idle(1);
        press(4'h5);
        check_val("div0_new", bus.num1, 16'h0005);

        // Underflow, then operator replace before num2 digits.
        press(4'hA); press(4'h3); press(4'hD); press(4'h7); press(4'hB);
        check_val("uflow_err", {15'h0, bus.err}, 16'h0001);
        press(4'h8); press(4'hD); press(4'hE); press(4'h2);
        check_val("op_repl", {12'h000, bus.op}, 16'h000E);
        check_val("op_repl_n2", bus.num2, 16'h0002);

        // Leading zeros fill num1.
        press(4'hA); press(4'h0); press(4'h0); press(4'h0); press(4'h0); press(4'h5);
        press(4'hC); press(4'h5);
        check_val("lead0_n2", bus.num2, 16'h0005);

        // CLR during the ALU wait, then reset with a key during the wait.
        press(4'hA); press(4'h1); press(4'hC); press(4'h2); press(4'hB);
        idle(1); press(4'hA); idle(LAT + 4);
        press(4'h1); press(4'hC); press(4'h2); press(4'hB);
        idle(1); step(1'b1, 4'h5, 1'b0); idle(LAT + 4);
        check_val("rst_exec_disp", bus.disp, 16'h0000);

        // Random key traffic.
        for (int i = 0; i < 4000; i++) begin
            kv = ($urandom_range(0, 2) != 0);
            r  = $urandom_range(0, 99);
            if (r < 55)      kc = 4'($urandom_range(0, 9));
            else if (r < 80) kc = 4'($urandom_range(12, 15));
            else if (r < 94) kc = 4'hB;
            else             kc = 4'hA;
            step(kv, kc, ($urandom_range(0, 299) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
